// File: rtl/video_pkg.sv
// Shared types and constants for the video sync decoder.
package video_pkg;

  localparam int H_W = 11;
  localparam int V_W = 10;

  localparam int NTSC_MAX_LINES_DEF = 286;
  localparam int H_TIMEOUT_DEF      = 2047;
  localparam int LOCK_FRAMES_DEF    = 2;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [H_W-1:0] sat_inc_h(input logic [H_W-1:0] v,
                                               input logic [H_W-1:0] lim);
    return (v == lim) ? v : v + H_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Strobe-qualified edge detector: remembers the value seen on the previous
// strobe and flags falls/rises on the current strobe.
module sync_edge_detect
  import video_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pix_stb,
  input  logic i_sig,
  output logic o_fall,
  output logic o_rise
);

  logic sig_q;

  // Previous-strobe sample; held between strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sig_q <= 1'b0;
    end else if (i_pix_stb) begin
      sig_q <= i_sig;
    end
  end

  assign o_fall = i_pix_stb &  sig_q & ~i_sig;
  assign o_rise = i_pix_stb & ~sig_q &  i_sig;

endmodule

// File: rtl/video_sync_decoder.sv
// Recovers raster timing from an active-low HS/VS pair plus blanking flags:
// line/frame measurement, PAL/NTSC detection, lock, and regenerated
// coordinates and start pulses.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   SEARCH  | no usable timing; waiting for a VS fall to start measuring
//   MEASURE | counting consecutive identical frames with stable lines
//   LOCKED  | timing stable; any line/frame length change drops to MEASURE
module video_sync_decoder
  import video_pkg::*;
#(
  parameter int NTSC_MAX_LINES = NTSC_MAX_LINES_DEF,
  parameter int LOCK_FRAMES    = LOCK_FRAMES_DEF,
  parameter int H_TIMEOUT      = H_TIMEOUT_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_pix_stb,
  input  logic           i_hs,
  input  logic           i_vs,
  input  logic           i_hblank,
  input  logic           i_vblank,
  output logic [H_W-1:0] o_x,
  output logic [8:0]     o_y,
  output logic           o_active,
  output logic [H_W-1:0] o_line_len,
  output logic [V_W-1:0] o_frame_lines,
  output logic           o_ntsc,
  output logic           o_locked,
  output logic           o_line_start,
  output logic           o_frame_start
);

  localparam logic [H_W-1:0] H_LIM    = H_W'(H_TIMEOUT);
  localparam logic [H_W-1:0] H_NEAR   = H_LIM - H_W'(1);
  localparam logic [H_W-1:0] X_MAX    = '1;
  localparam logic [V_W-1:0] NTSC_LIM = V_W'(NTSC_MAX_LINES);
  localparam int             M_W      = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [M_W-1:0] LOCK_N   = M_W'(LOCK_FRAMES);

  logic hs_fall, hs_rise;
  logic vs_fall, vs_rise;
  logic hb_fall, hb_rise;
  logic unused_rise;

  sync_edge_detect u_hs_edge (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_pix_stb (i_pix_stb),
    .i_sig     (i_hs),
    .o_fall    (hs_fall),
    .o_rise    (hs_rise)
  );

  sync_edge_detect u_vs_edge (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_pix_stb (i_pix_stb),
    .i_sig     (i_vs),
    .o_fall    (vs_fall),
    .o_rise    (vs_rise)
  );

  sync_edge_detect u_hb_edge (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_pix_stb (i_pix_stb),
    .i_sig     (i_hblank),
    .o_fall    (hb_fall),
    .o_rise    (hb_rise)
  );

  // Rising edges are not needed for decoding.
  assign unused_rise = hs_rise | vs_rise | hb_rise;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [H_W-1:0] h_period;
  logic [V_W-1:0] frame_meas;
  logic           h_sat;
  logic           timeout_evt;
  logic           line_stable;
  logic           first_line;
  logic           prev_valid;
  logic [M_W-1:0] match_cnt;
  logic [M_W-1:0] match_nxt;
  sync_state_t    state;

  assign h_period   = h_cnt + H_W'(1);
  // An HS fall on the same strobe as the VS fall closes the ending frame.
  assign frame_meas = v_cnt + {{(V_W-1){1'b0}}, hs_fall};
  assign h_sat      = (h_cnt == H_LIM);
  // Fires on the strobe h_cnt reaches the limit and keeps firing while it
  // stays saturated, so the FSM cannot leave SEARCH without HS activity.
  assign timeout_evt = i_pix_stb & ~hs_fall & (h_cnt >= H_NEAR);
  assign match_nxt  = match_cnt + M_W'(1);

  // Horizontal period counter, line length measurement and line pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt        <= '0;
      o_line_len   <= '0;
      o_line_start <= 1'b0;
    end else begin
      o_line_start <= hs_fall;
      if (i_pix_stb) begin
        if (hs_fall) begin
          h_cnt <= '0;
          // A period that ran into the timeout is not a measurement.
          if (!h_sat) begin
            o_line_len <= h_period;
          end
        end else begin
          h_cnt <= sat_inc_h(h_cnt, H_LIM);
        end
      end
    end
  end

  // Line counter, frame height measurement and frame pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_cnt         <= '0;
      o_frame_lines <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= vs_fall;
      if (vs_fall) begin
        o_frame_lines <= frame_meas;
        v_cnt         <= '0;
      end else if (hs_fall) begin
        v_cnt <= v_cnt + V_W'(1);
      end
    end
  end

  // Per-frame line stability: armed at the second HS fall, any period change
  // clears it until the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_stable <= 1'b0;
    end else if (vs_fall) begin
      line_stable <= 1'b0;
    end else if (hs_fall) begin
      if (h_period != o_line_len) begin
        line_stable <= 1'b0;
      end else if (v_cnt == V_W'(1)) begin
        line_stable <= 1'b1;
      end
    end
  end

  // Lock state machine with registered lock/standard outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      prev_valid <= 1'b0;
      o_locked   <= 1'b0;
      o_ntsc     <= 1'b0;
    end else if (i_pix_stb) begin
      if (timeout_evt) begin
        state      <= SEARCH;
        match_cnt  <= '0;
        prev_valid <= 1'b0;
        o_locked   <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (vs_fall) begin
              state      <= MEASURE;
              match_cnt  <= '0;
              prev_valid <= 1'b0;
            end
          end
          MEASURE: begin
            if (vs_fall) begin
              prev_valid <= 1'b1;
              if (prev_valid && (frame_meas == o_frame_lines) && line_stable) begin
                match_cnt <= match_nxt;
                if (match_nxt == LOCK_N) begin
                  state    <= LOCKED;
                  o_locked <= 1'b1;
                  o_ntsc   <= (frame_meas < NTSC_LIM);
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if ((hs_fall && (h_period != o_line_len)) ||
                (vs_fall && (frame_meas != o_frame_lines))) begin
              state     <= MEASURE;
              match_cnt <= '0;
              o_locked  <= 1'b0;
            end
          end
          default: begin
            state     <= SEARCH;
            match_cnt <= '0;
            o_locked  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Regenerated pixel/line coordinates and active flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x        <= '0;
      o_y        <= '0;
      o_active   <= 1'b0;
      first_line <= 1'b1;
    end else if (i_pix_stb) begin
      o_active <= ~i_hblank & ~i_vblank;
      if (i_hblank || hb_fall) begin
        o_x <= '0;
      end else begin
        o_x <= sat_inc_h(o_x, X_MAX);
      end
      if (i_vblank) begin
        first_line <= 1'b1;
      end else if (hb_fall) begin
        o_y        <= first_line ? 9'd0 : o_y + 9'd1;
        first_line <= 1'b0;
      end
    end
  end

endmodule
